// File: rtl/sid_voice_ctrl.sv
// SID-style voice register controller: byte-wide shadow bank, atomic commit into the active bank,
// and per-voice gate re-trigger sequencing. Define SID_CTRL_READBACK_EN for a registered shadow read port.
module sid_voice_ctrl #(
  parameter int NUM_VOICES    = 3,
  parameter int RETRIG_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                bus_addr,
  input  logic [7:0]                bus_wdata,
  input  logic                      bus_we,
  output logic                      bus_ready,
`ifdef SID_CTRL_READBACK_EN
  input  logic                      bus_re,
  output logic [7:0]                bus_rdata,
`endif
  input  logic                      commit_tick,
  output logic [16*NUM_VOICES-1:0]  freq_o,
  output logic [16*NUM_VOICES-1:0]  dur_o,
  output logic [8*NUM_VOICES-1:0]   attack_o,
  output logic [8*NUM_VOICES-1:0]   sustain_o,
  output logic [8*NUM_VOICES-1:0]   waveform_o,
  output logic                      busy
);
  typedef enum logic {ST_IDLE, ST_FORCE_LOW} state_t;
  localparam logic [7:0] CNT_INIT = 8'(RETRIG_CYCLES - 1);

  logic [15:0] sh_freq_q [NUM_VOICES], sh_freq_d [NUM_VOICES];
  logic [11:0] sh_dur_q  [NUM_VOICES], sh_dur_d  [NUM_VOICES];
  logic [7:0]  sh_ctrl_q [NUM_VOICES], sh_ctrl_d [NUM_VOICES];
  logic [7:0]  sh_att_q  [NUM_VOICES], sh_att_d  [NUM_VOICES];
  logic [7:0]  sh_sus_q  [NUM_VOICES], sh_sus_d  [NUM_VOICES];
  logic [15:0] act_freq_q [NUM_VOICES], act_freq_d [NUM_VOICES];
  logic [11:0] act_dur_q  [NUM_VOICES], act_dur_d  [NUM_VOICES];
  logic [7:0]  act_ctrl_q [NUM_VOICES], act_ctrl_d [NUM_VOICES];
  logic [7:0]  act_att_q  [NUM_VOICES], act_att_d  [NUM_VOICES];
  logic [7:0]  act_sus_q  [NUM_VOICES], act_sus_d  [NUM_VOICES];
  logic        rp_q    [NUM_VOICES], rp_d    [NUM_VOICES];
  state_t      state_q [NUM_VOICES], state_d [NUM_VOICES];
  logic [7:0]  cnt_q   [NUM_VOICES], cnt_d   [NUM_VOICES];
  logic        hit     [NUM_VOICES];
  logic [2:0]  off     [NUM_VOICES];
  logic        wr_acc;

  assign bus_ready = ~rst & ~commit_tick;
  assign wr_acc    = bus_we & bus_ready;

  // Address decode: which voice window the address falls in, and the byte offset within it.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit[v] = (int'(bus_addr) >= 7*v) && (int'(bus_addr) < 7*v + 7);
      off[v] = 3'(int'(bus_addr) - 7*v);
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      sh_freq_d[v]  = sh_freq_q[v];
      sh_dur_d[v]   = sh_dur_q[v];
      sh_ctrl_d[v]  = sh_ctrl_q[v];
      sh_att_d[v]   = sh_att_q[v];
      sh_sus_d[v]   = sh_sus_q[v];
      act_freq_d[v] = act_freq_q[v];
      act_dur_d[v]  = act_dur_q[v];
      act_ctrl_d[v] = act_ctrl_q[v];
      act_att_d[v]  = act_att_q[v];
      act_sus_d[v]  = act_sus_q[v];
      rp_d[v]       = rp_q[v];
      state_d[v]    = state_q[v];
      cnt_d[v]      = cnt_q[v];

      if (state_q[v] == ST_FORCE_LOW) begin
        if (cnt_q[v] == 8'd0) state_d[v] = ST_IDLE;
        else                  cnt_d[v]   = cnt_q[v] - 8'd1;
      end

      // Commit and write never coincide: bus_ready is low on commit cycles.
      if (commit_tick) begin
        act_freq_d[v] = sh_freq_q[v];
        act_dur_d[v]  = sh_dur_q[v];
        act_ctrl_d[v] = sh_ctrl_q[v];
        act_att_d[v]  = sh_att_q[v];
        act_sus_d[v]  = sh_sus_q[v];
        rp_d[v]       = 1'b0;
        if (rp_q[v] && sh_ctrl_q[v][0]) begin
          state_d[v] = ST_FORCE_LOW;
          cnt_d[v]   = CNT_INIT;
        end else if (!sh_ctrl_q[v][0]) begin
          state_d[v] = ST_IDLE;
          cnt_d[v]   = 8'd0;
        end
      end

      if (wr_acc && hit[v]) begin
        case (off[v])
          3'd0: sh_freq_d[v][7:0]  = bus_wdata;
          3'd1: sh_freq_d[v][15:8] = bus_wdata;
          3'd2: sh_dur_d[v][7:0]   = bus_wdata;
          3'd3: sh_dur_d[v][11:8]  = bus_wdata[3:0];
          3'd4: begin
            sh_ctrl_d[v] = bus_wdata;
            if (bus_wdata[0] && sh_ctrl_q[v][0]) rp_d[v] = 1'b1;
            else if (!bus_wdata[0])              rp_d[v] = 1'b0;
          end
          3'd5: sh_att_d[v] = bus_wdata;
          3'd6: sh_sus_d[v] = bus_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rst) begin
        sh_freq_q[v]  <= '0;
        sh_dur_q[v]   <= '0;
        sh_ctrl_q[v]  <= '0;
        sh_att_q[v]   <= '0;
        sh_sus_q[v]   <= '0;
        act_freq_q[v] <= '0;
        act_dur_q[v]  <= '0;
        act_ctrl_q[v] <= '0;
        act_att_q[v]  <= '0;
        act_sus_q[v]  <= '0;
        rp_q[v]       <= 1'b0;
        state_q[v]    <= ST_IDLE;
        cnt_q[v]      <= '0;
      end else begin
        sh_freq_q[v]  <= sh_freq_d[v];
        sh_dur_q[v]   <= sh_dur_d[v];
        sh_ctrl_q[v]  <= sh_ctrl_d[v];
        sh_att_q[v]   <= sh_att_d[v];
        sh_sus_q[v]   <= sh_sus_d[v];
        act_freq_q[v] <= act_freq_d[v];
        act_dur_q[v]  <= act_dur_d[v];
        act_ctrl_q[v] <= act_ctrl_d[v];
        act_att_q[v]  <= act_att_d[v];
        act_sus_q[v]  <= act_sus_d[v];
        rp_q[v]       <= rp_d[v];
        state_q[v]    <= state_d[v];
        cnt_q[v]      <= cnt_d[v];
      end
    end
  end

  // Effective gate is masked while a voice is being held low for its re-trigger.
  always_comb begin
    busy = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      freq_o[16*v +: 16]    = act_freq_q[v];
      dur_o[16*v +: 16]     = {4'h0, act_dur_q[v]};
      attack_o[8*v +: 8]    = act_att_q[v];
      sustain_o[8*v +: 8]   = act_sus_q[v];
      waveform_o[8*v +: 8]  = {act_ctrl_q[v][7:1], act_ctrl_q[v][0] & (state_q[v] == ST_IDLE)};
      busy                  = busy | (state_q[v] == ST_FORCE_LOW);
    end
  end

`ifdef SID_CTRL_READBACK_EN
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (bus_re) begin
      rdata_d = 8'h00;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (hit[v]) begin
          case (off[v])
            3'd0:    rdata_d = sh_freq_q[v][7:0];
            3'd1:    rdata_d = sh_freq_q[v][15:8];
            3'd2:    rdata_d = sh_dur_q[v][7:0];
            3'd3:    rdata_d = {4'h0, sh_dur_q[v][11:8]};
            3'd4:    rdata_d = sh_ctrl_q[v];
            3'd5:    rdata_d = sh_att_q[v];
            3'd6:    rdata_d = sh_sus_q[v];
            default: rdata_d = 8'h00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= rdata_d;
  end

  assign bus_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sid_voice_ctrl.sv
// Scoreboard bench for sid_voice_ctrl: directed scenarios followed by randomized bus traffic,
// checked against a byte-array reference model with a remaining-low-cycles count per voice.
module tb_sid_voice_ctrl;
  localparam int NV = 3;
  localparam int RC = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       bus_addr;
  logic [7:0]       bus_wdata;
  logic             bus_we;
  logic             bus_ready;
  logic             commit_tick;
  logic [16*NV-1:0] freq_o;
  logic [16*NV-1:0] dur_o;
  logic [8*NV-1:0]  attack_o;
  logic [8*NV-1:0]  sustain_o;
  logic [8*NV-1:0]  waveform_o;
  logic             busy;
`ifdef SID_CTRL_READBACK_EN
  logic             bus_re;
  logic [7:0]       bus_rdata;
`endif

  sid_voice_ctrl #(.NUM_VOICES(NV), .RETRIG_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_ready(bus_ready),
`ifdef SID_CTRL_READBACK_EN
    .bus_re(bus_re), .bus_rdata(bus_rdata),
`endif
    .commit_tick(commit_tick), .freq_o(freq_o), .dur_o(dur_o), .attack_o(attack_o),
    .sustain_o(sustain_o), .waveform_o(waveform_o), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] freq;
    logic [63:0] dur;
    logic [31:0] att;
    logic [31:0] sus;
    logic [31:0] wav;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: raw register bytes by (voice, offset) and cycles left with the gate held low.
  logic [7:0] m_sh  [4][7];
  logic [7:0] m_act [4][7];
  bit         m_rp  [4];
  int         m_rem [4];

  function automatic void m_reset();
    for (int v = 0; v < 4; v++) begin
      for (int o = 0; o < 7; o++) begin
        m_sh[v][o]  = 8'h00;
        m_act[v][o] = 8'h00;
      end
      m_rp[v]  = 1'b0;
      m_rem[v] = 0;
    end
  endfunction

  function automatic void m_update(bit r, bit wacc, int a, logic [7:0] d, bit c);
    int v, o;
    if (r) begin
      m_reset();
      return;
    end
    for (int i = 0; i < NV; i++) if (m_rem[i] > 0) m_rem[i]--;
    if (c) begin
      for (int i = 0; i < NV; i++) begin
        if (m_rp[i] && m_sh[i][4][0]) m_rem[i] = RC;
        else if (!m_sh[i][4][0])      m_rem[i] = 0;
        for (int o2 = 0; o2 < 7; o2++) m_act[i][o2] = m_sh[i][o2];
        m_rp[i] = 1'b0;
      end
    end
    if (wacc && a < 7*NV) begin
      v = a / 7;
      o = a % 7;
      if (o == 4) begin
        if (d[0] && m_sh[v][4][0]) m_rp[v] = 1'b1;
        else if (!d[0])            m_rp[v] = 1'b0;
      end
      m_sh[v][o] = (o == 3) ? (d & 8'h0F) : d;
    end
  endfunction

  function automatic exp_t snap(logic rdy);
    exp_t e;
    e.freq = '0; e.dur = '0; e.att = '0; e.sus = '0; e.wav = '0;
    e.busy = 1'b0;
    e.ready = rdy;
    for (int v = 0; v < NV; v++) begin
      e.freq[16*v +: 16] = {m_act[v][1], m_act[v][0]};
      e.dur[16*v +: 16]  = {m_act[v][3], m_act[v][2]};
      e.att[8*v +: 8]    = m_act[v][5];
      e.sus[8*v +: 8]    = m_act[v][6];
      e.wav[8*v +: 8]    = {m_act[v][4][7:1], m_act[v][4][0] & (m_rem[v] == 0)};
      if (m_rem[v] > 0) e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle; expectation for the half-cycle sample is queued before the edge.
  task automatic step(input bit r, input bit we, input logic [4:0] a, input logic [7:0] d, input bit c);
    rst = r; bus_we = we; bus_addr = a; bus_wdata = d; commit_tick = c;
    exp_q.push_back(snap(!r && !c));
    @(posedge clk);
    m_update(r, we && !r && !c, int'(a), d, c);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("freq_o",     64'(freq_o),     e.freq);
        chk("dur_o",      64'(dur_o),      e.dur);
        chk("attack_o",   64'(attack_o),   64'(e.att));
        chk("sustain_o",  64'(sustain_o),  64'(e.sus));
        chk("waveform_o", 64'(waveform_o), 64'(e.wav));
        chk("busy",       64'(busy),       64'(e.busy));
        chk("bus_ready",  64'(bus_ready),  64'(e.ready));
      end
    end
  end

  initial begin : driver
    bit          pend;
    logic [4:0]  pa;
    logic [7:0]  pd;
    bit          c, r;
    rst = 1'b1; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; commit_tick = 1'b0;
`ifdef SID_CTRL_READBACK_EN
    bus_re = 1'b0;
`endif
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("reset_waveform", 64'(waveform_o), 64'h0);
    chk("reset_ready",    64'(bus_ready),  64'h0);

    // Frequency write becomes visible only after commit.
    wr(5'd0, 8'h34);
    wr(5'd1, 8'h12);
    chk("freq_v0_pre_commit", 64'(freq_o[15:0]), 64'h0000);
    commit();
    chk("freq_v0_post_commit", 64'(freq_o[15:0]), 64'h1234);
    chk("freq_v12_zero", 64'(freq_o[47:16]), 64'h0);

    // Upper pulse-width nibble only.
    wr(5'd10, 8'hFF);
    commit();
    chk("dur_v1", 64'(dur_o[31:16]), 64'h0F00);

    // Write colliding with commit is held off and lands afterwards.
    step(1'b0, 1'b1, 5'd5, 8'hA9, 1'b1);
    chk("ready_on_commit", 64'(bus_ready), 64'h0);
    wr(5'd5, 8'hA9);
    chk("attack_before_commit", 64'(attack_o[7:0]), 64'h00);
    commit();
    chk("attack_after_commit", 64'(attack_o[7:0]), 64'hA9);

    // Voice 2 re-trigger: gate held low for RC cycles.
    wr(5'd18, 8'h41);
    commit();
    chk("v2_gate_on", 64'(waveform_o[16]), 64'h1);
    wr(5'd18, 8'h41);
    commit();
    for (int i = 0; i < RC; i++) begin
      chk("v2_retrig_gate_low", 64'(waveform_o[16]), 64'h0);
      chk("v2_retrig_busy",     64'(busy),           64'h1);
      chk("v2_ctrl_upper",      64'(waveform_o[23:17]), 64'h20);
      if (i < RC - 1) idle();
    end
    idle();
    chk("v2_gate_restored", 64'(waveform_o[16]), 64'h1);
    chk("v2_busy_clear",    64'(busy),           64'h0);

    // Abort a re-trigger by committing a gate-off control byte.
    wr(5'd18, 8'h41);
    commit();
    wr(5'd18, 8'h40);
    chk("v2_abort_busy_before", 64'(busy), 64'h1);
    commit();
    chk("v2_abort_busy", 64'(busy), 64'h0);
    chk("v2_abort_gate", 64'(waveform_o[16]), 64'h0);

    // Unmapped write, then reset in the middle of a forced-low window.
    wr(5'd25, 8'hFF);
    wr(5'd4, 8'h01);
    commit();
    wr(5'd4, 8'h01);
    commit();
    idle();
    chk("v0_mid_retrig_busy", 64'(busy), 64'h1);
    step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("rst_freq",  64'(freq_o),     64'h0);
    chk("rst_wave",  64'(waveform_o), 64'h0);
    chk("rst_busy",  64'(busy),       64'h0);
    idle();
    chk("ready_after_rst", 64'(bus_ready), 64'h1);

    // Randomized traffic with a master that holds writes until accepted.
    pend = 1'b0; pa = '0; pd = '0;
    for (int n = 0; n < 800; n++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        if ($urandom_range(0, 1) == 0) pa = 5'(7 * $urandom_range(0, NV - 1) + 4);
        else                           pa = 5'($urandom_range(0, 31));
        pd = 8'($urandom);
      end
      c = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(r, pend, pa, pd, c);
      if (pend && !r && !c) pend = 1'b0;
    end
    idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sid_voice_ctrl.md
Name: sid_voice_ctrl

Overview:
Host-facing register controller for a bank of sid_voice instances. It accepts byte writes in a SID-style register map into per-voice shadow registers. On a sample-rate commit strobe it copies all shadow registers atomically into the active registers that drive the voices. It also sequences gate re-triggers: when a gate is re-asserted while already high, the voice gate is forced low for a fixed number of cycles so the ADSR restarts.

Parameters:
NUM_VOICES, 3, number of voices controlled (1..4); register map stride 7 per voice.
RETRIG_CYCLES, 4, cycles the gate is held low on a re-trigger (1..255).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
bus_addr  in  5  register address
bus_wdata  in  8  write data
bus_we  in  1  write request; held by master until bus_ready
bus_ready  out  1  write accepted this cycle when bus_we&bus_ready
commit_tick  in  1  1-cycle strobe; shadow->active transfer
freq_o  out  16*NUM_VOICES  active frequency, voice v at [16v+15:16v]
dur_o  out  16*NUM_VOICES  active pulse width, [15:12] always 0
attack_o  out  8*NUM_VOICES  active attack/decay
sustain_o  out  8*NUM_VOICES  active sustain/release
waveform_o  out  8*NUM_VOICES  active control byte, bit0 = effective gate
busy  out  1  OR of all voices in FORCE_LOW

Behaviour:
- Map for voice v, base = 7v:
  - +0 freq[7:0], +1 freq[15:8]
  - +2 dur[7:0], +3 dur[11:8] (wdata[3:0] only)
  - +4 control, +5 attack, +6 sustain
- Addresses >= 7*NUM_VOICES: write accepted (bus_ready=1) and dropped.
- bus_ready = ~rst & ~commit_tick (combinational).
  - A write coinciding with commit_tick is not accepted; the master holds it and it lands after the commit.
  - Accepted writes update the shadow register on the next clk edge.
- Commit: on a cycle with commit_tick=1, every active register <= shadow, all voices together in one edge. Outputs change the cycle after commit_tick.
- Retrigger pending flag rp[v]:
  - Set when control is written with wdata[0]=1 while shadow gate is already 1.
  - Cleared on commit.
  - Writing control with wdata[0]=0 clears rp[v].
- Per-voice FSM, states IDLE and FORCE_LOW, 8-bit counter cnt[v]:
  - IDLE -> FORCE_LOW on commit with rp[v]=1 and shadow gate=1; cnt <= RETRIG_CYCLES-1.
  - In FORCE_LOW, cnt decrements each cycle. At cnt=0 the next state is IDLE.
  - Effective gate is 0 for exactly RETRIG_CYCLES cycles starting the cycle after commit, then follows active gate.
  - Commit during FORCE_LOW with rp=1 and gate=1: counter reloads (restart).
  - Commit during FORCE_LOW with shadow gate=0: abort to IDLE; gate stays 0 via the active value.
  - Commit during FORCE_LOW with rp=0 and gate=1: continue counting.
- waveform_o[8v+7:8v+1] = active control[7:1]; bit0 = active gate & (state==IDLE).
- Reset: all shadow, active, rp and cnt = 0; FSMs IDLE; all outputs 0; bus_ready 0 during rst.
- Reset mid-FORCE_LOW: returns to IDLE with gate 0 on the next edge.

Optional Feature:
- Macro SID_CTRL_READBACK_EN.
- Defined:
  - Adds ports bus_re (in, 1) and bus_rdata (out, 8).
  - bus_rdata is registered, 1-cycle latency, and returns the shadow byte at bus_addr.
  - Reserved bits read 0; unmapped addresses read 0x00.
  - Reset value 0x00; bus_rdata holds its value when bus_re=0.
- Undefined: no read ports; shadow registers are write-only.

Test Plan:
- Reset, then write voice0 +0=0x34, +1=0x12 and pulse commit_tick -> freq_o[15:0]=0x0000 before commit, 0x1234 the cycle after commit; other voices 0.
- Write +3=0xFF for voice1, then commit -> dur_o[31:16]=0x0F00.
- Assert bus_we (addr 5, data 0xA9) in the same cycle as commit_tick -> bus_ready=0 that cycle; write lands the following cycle; attack_o[7:0]=0xA9 only after the next commit.
- Voice2: write control=0x41 and commit; write 0x41 again and commit -> waveform_o bit16 = 0 for 4 cycles, busy=1 for those cycles, then bit16=1; waveform_o[23:17]=0x20 throughout.
- Start a retrigger, then 2 cycles later write control=0x40 and commit -> FSM aborts, gate 0, busy=0 the cycle after that commit.
- Write address 25, then assert rst mid-FORCE_LOW -> no register changes from the address-25 write; all outputs 0 after reset; bus_ready=1 once rst deasserts.
